// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline-stage register: occupancy state encodings.
package pipe_stage_skid_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_SKID  = 2'd2;

endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One payload entry of the stage: a plain register with synchronous clear and load.
module pipe_entry #(
   parameter int unsigned W = 40
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         q <= '0;
      else if (clear)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, run-enable/flush clearing and a saturating stall counter.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int unsigned CTRL_W      = 8,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned SKID        = 1,
   parameter int unsigned ZERO_BUBBLE = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int unsigned PW = CTRL_W + DATA_W;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          run_ok;
   logic          clear;
   logic          in_fire;
   logic          out_fire;
   logic          main_load;
   logic          skid_load;
   logic [PW-1:0] in_word;
   logic [PW-1:0] main_d;
   logic [PW-1:0] main_q;
   logic [PW-1:0] skid_q;

   // Keeps in_ready low while reset is held and for the first edge after release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         run_ok <= 1'b0;
      else
         run_ok <= 1'b1;
   end

   assign out_valid = (state != ST_EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign clear     = !start | flush;
   assign in_word   = {in_ctrl, in_data};

   generate
      if (SKID != 0) begin : g_rdy_skid
         assign in_ready = run_ok & start & (state != ST_SKID);
      end else begin : g_rdy_flow
         assign in_ready = run_ok & start & ((state == ST_EMPTY) | out_ready);
      end
   endgenerate

   always_comb begin
      state_nxt = state;
      main_load = 1'b0;
      skid_load = 1'b0;
      if (clear) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_nxt = ST_FULL;
                  main_load = 1'b1;
               end
            end
            ST_FULL: begin
               if (in_fire && out_fire) begin
                  main_load = 1'b1;
               end else if (in_fire && (SKID != 0)) begin
                  state_nxt = ST_SKID;
                  skid_load = 1'b1;
               end else if (out_fire) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_fire) begin
                  state_nxt = ST_FULL;
                  main_load = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_EMPTY;
      else
         state <= state_nxt;
   end

   // Main refills from the skid entry first so payload order stays FIFO.
   assign main_d = (state == ST_SKID) ? skid_q : in_word;

   pipe_entry #(.W(PW)) u_main (
      .clk   (clk),
      .reset (reset),
      .load  (main_load),
      .clear (clear),
      .d     (main_d),
      .q     (main_q)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_entry #(.W(PW)) u_skid (
            .clk   (clk),
            .reset (reset),
            .load  (skid_load),
            .clear (clear),
            .d     (in_word),
            .q     (skid_q)
         );
      end else begin : g_no_skid
         assign skid_q = '0;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         stall_cnt <= '0;
      else if (start && out_valid && !out_ready && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 1'b1;
   end

   assign out_ctrl = ((ZERO_BUBBLE != 0) && !out_valid) ? '0 : main_q[PW-1:DATA_W];
   assign out_data = ((ZERO_BUBBLE != 0) && !out_valid) ? '0 : main_q[DATA_W-1:0];

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: instance 0 uses the skid buffer, instance 1 is single-entry with a 4-bit stall counter.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        reset;
   logic        start [2];
   logic        flush [2];
   logic        iv    [2];
   logic        ordy  [2];
   logic [7:0]  ictl  [2];
   logic [31:0] idat  [2];
   logic        ir    [2];
   logic        ov    [2];
   logic [7:0]  octl  [2];
   logic [31:0] odat  [2];
   logic [15:0] sc_a;
   logic [3:0]  sc_b;

   logic [39:0] sb [2][$];
   int unsigned stall_exp [2];
   int unsigned cnt_acc   [2];
   int unsigned cnt_out   [2];
   int unsigned n_checks = 0;
   int unsigned n_err    = 0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.CTRL_W(8), .DATA_W(32), .SKID(1), .ZERO_BUBBLE(1), .CNT_W(16)) u_dut_a (
      .clk(clk), .reset(reset), .start(start[0]), .flush(flush[0]),
      .in_valid(iv[0]), .in_ready(ir[0]), .in_ctrl(ictl[0]), .in_data(idat[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_ctrl(octl[0]), .out_data(odat[0]),
      .stall_cnt(sc_a)
   );

   pipe_stage_skid #(.CTRL_W(8), .DATA_W(32), .SKID(0), .ZERO_BUBBLE(1), .CNT_W(4)) u_dut_b (
      .clk(clk), .reset(reset), .start(start[1]), .flush(flush[1]),
      .in_valid(iv[1]), .in_ready(ir[1]), .in_ctrl(ictl[1]), .in_data(idat[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_ctrl(octl[1]), .out_data(odat[1]),
      .stall_cnt(sc_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_word(input int k, input logic [31:0] w);
      idat[k] = w;
      ictl[k] = w[7:0] ^ 8'h5A;
   endtask

   // Called just after a negedge with inputs already driven; returns at the next negedge.
   task automatic tick();
      logic acc [2];
      #1;
      for (int k = 0; k < 2; k++) begin
         int unsigned sz;
         int unsigned smax;
         logic        exp_ir;
         logic [15:0] sc;
         sz     = sb[k].size();
         smax   = (k == 0) ? 65535 : 15;
         sc     = (k == 0) ? sc_a : {12'd0, sc_b};
         exp_ir = start[k] & ((k == 0) ? (sz < 2) : ((sz == 0) | ordy[k]));
         acc[k] = 1'b0;
         chk($sformatf("stall%0d", k), 64'(sc), 64'(stall_exp[k]));
         chk($sformatf("valid%0d", k), 64'(ov[k]), 64'(sz != 0));
         chk($sformatf("ready%0d", k), 64'(ir[k]), 64'(exp_ir));
         if (sz == 0)
            chk($sformatf("bubble%0d", k), {24'd0, octl[k], odat[k]}, 64'd0);
         if (sz != 0 && ordy[k]) begin
            chk($sformatf("data%0d", k), {24'd0, octl[k], odat[k]}, {24'd0, sb[k][0]});
            void'(sb[k].pop_front());
            cnt_out[k]++;
         end
         if (iv[k] && exp_ir) begin
            acc[k] = 1'b1;
            if (!flush[k]) begin
               sb[k].push_back({ictl[k], idat[k]});
               cnt_acc[k]++;
            end
         end
         if (!start[k] || flush[k])
            sb[k].delete();
         if (start[k] && sz != 0 && !ordy[k] && stall_exp[k] != smax)
            stall_exp[k]++;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         if (acc[k])
            set_word(k, idat[k] + 32'd1);
   endtask

   task automatic drain(input int k);
      iv[k]   = 1'b0;
      ordy[k] = 1'b1;
      for (int n = 0; n < 20 && sb[k].size() != 0; n++)
         tick();
      tick();
      chk($sformatf("drain%0d", k), 64'(sb[k].size()), 64'd0);
   endtask

   initial begin
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0; flush[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0;
         set_word(k, 32'd0);
         stall_exp[k] = 0; cnt_acc[k] = 0; cnt_out[k] = 0;
      end
      repeat (2) @(negedge clk);
      chk("rst_valid", 64'(ov[0]), 64'd0);
      chk("rst_ready", 64'(ir[0]), 64'd0);
      chk("rst_data", {24'd0, octl[0], odat[0]}, 64'd0);
      chk("rst_stall", 64'(sc_a), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // streaming 0x1..0x10 at full throughput
      start[0] = 1'b1; iv[0] = 1'b1; ordy[0] = 1'b1; set_word(0, 32'h1);
      for (int n = 0; n < 40 && cnt_acc[0] < 16; n++)
         tick();
      chk("t1_acc", 64'(cnt_acc[0]), 64'd16);
      drain(0);
      chk("t1_out", 64'(cnt_out[0]), 64'd16);
      chk("t1_stall", 64'(sc_a), 64'd0);

      // skid fill while stalled, then release in order
      cnt_acc[0] = 0;
      iv[0] = 1'b1; ordy[0] = 1'b0; set_word(0, 32'hA);
      repeat (4) tick();
      chk("t2_acc", 64'(cnt_acc[0]), 64'd2);
      chk("t2_stall", 64'(sc_a), 64'd3);
      ordy[0] = 1'b1;
      for (int n = 0; n < 10 && cnt_acc[0] < 3; n++)
         tick();
      chk("t2_acc3", 64'(cnt_acc[0]), 64'd3);
      drain(0);

      // flush while both entries are occupied and 0x55 is offered
      iv[0] = 1'b1; ordy[0] = 1'b0; set_word(0, 32'h20);
      repeat (2) tick();
      set_word(0, 32'h55); flush[0] = 1'b1;
      tick();
      flush[0] = 1'b0; iv[0] = 1'b0;
      chk("t3_valid", 64'(ov[0]), 64'd0);
      chk("t3_data", {24'd0, octl[0], odat[0]}, 64'd0);
      drain(0);

      // start dropped for two cycles mid-stream
      iv[0] = 1'b1; ordy[0] = 1'b1; set_word(0, 32'h100);
      repeat (5) tick();
      start[0] = 1'b0;
      tick();
      chk("t4_valid", 64'(ov[0]), 64'd0);
      chk("t4_ready", 64'(ir[0]), 64'd0);
      tick();
      start[0] = 1'b1;
      repeat (5) tick();
      drain(0);

      // single-entry variant under random backpressure
      cnt_acc[1] = 0; cnt_out[1] = 0;
      start[1] = 1'b1; set_word(1, 32'h1000);
      for (int n = 0; n < 10000 && cnt_acc[1] < 1000; n++) begin
         iv[1]   = ($urandom_range(0, 3) != 0);
         ordy[1] = $urandom_range(0, 1) != 0;
         tick();
      end
      chk("t5_acc", 64'(cnt_acc[1]), 64'd1000);
      drain(1);
      chk("t5_out", 64'(cnt_out[1]), 64'd1000);

      // 4-bit stall counter saturation, then async reset mid-stall
      iv[1] = 1'b1; ordy[1] = 1'b0; set_word(1, 32'h77);
      tick();
      iv[1] = 1'b0;
      repeat (20) tick();
      chk("t6_sat", 64'(sc_b), 64'd15);
      chk("t6_hold", 64'(ov[1]), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("t6_valid", 64'(ov[1]), 64'd0);
      chk("t6_ready", 64'(ir[1]), 64'd0);
      chk("t6_data", {24'd0, octl[1], odat[1]}, 64'd0);
      chk("t6_stall", 64'(sc_b), 64'd0);
      for (int k = 0; k < 2; k++) begin
         sb[k].delete();
         stall_exp[k] = 0;
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      iv[1] = 1'b1; ordy[1] = 1'b1; set_word(1, 32'h99);
      cnt_acc[1] = 0;
      tick();
      chk("t6_reacc", 64'(cnt_acc[1]), 64'd1);
      drain(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
